// File: rtl/addatone_pkg.sv
// Shared constants and types for the addatone ADC/controller path.
`timescale 1ns / 1ps

package addatone_pkg;

  localparam int unsigned ADC_WORD_BITS      = 16;
  localparam int unsigned ADC_TIMEOUT_CYCLES = 64;

  typedef logic [ADC_WORD_BITS-1:0] adc_word_t;

  // Receiver frame state: IDLE means no bits of the current frame held yet.
  typedef enum logic {
    StIdle,
    StShift
  } adc_rx_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser with a rising-edge strobe on the synchronised signal.
`timescale 1ns / 1ps

module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // Shift the asynchronous input through the synchroniser chain and keep a
  // delayed copy of the last stage for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/adc_spi_rx.sv
// Deserialises MSB-first words from the chip-select-less ADC SPI link into the
// crystal_osc domain; an inactivity timeout drops truncated frames.
`timescale 1ns / 1ps

module adc_spi_rx
  import addatone_pkg::*;
#(
  parameter int unsigned WORD_BITS      = ADC_WORD_BITS,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = ADC_TIMEOUT_CYCLES
) (
  input  logic                 crystal_osc,
  input  logic                 rstn,
  input  logic                 adc_spi_clock,
  input  logic                 adc_spi_data,
  output logic [WORD_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(WORD_BITS);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CntW-1:0] LastBit = CntW'(WORD_BITS - 1);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYCLES);

  logic sck_rise;
  logic sck_sync_unused;
  logic sdi_sync;
  logic sdi_rise_unused;

  adc_rx_state_e        state_q, state_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic [WORD_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  // Equal-depth synchronisers keep MOSI aligned with the detected SCK edge.
  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sck_sync (
    .clk  (crystal_osc),
    .rstn (rstn),
    .din  (adc_spi_clock),
    .dout (sck_sync_unused),
    .rise (sck_rise)
  );

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sdi_sync (
    .clk  (crystal_osc),
    .rstn (rstn),
    .din  (adc_spi_data),
    .dout (sdi_sync),
    .rise (sdi_rise_unused)
  );

  // Next-state logic: shift on each SCK rise, complete on the last bit, and
  // drop the frame once the timeout has saturated with no edge pending.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (sck_rise) begin
          shift_d   = {shift_q[WORD_BITS-2:0], sdi_sync};
          bit_cnt_d = CntW'(1);
          state_d   = StShift;
        end
      end

      StShift: begin
        if (sck_rise) begin
          // An edge coinciding with expiry still counts as a valid bit.
          shift_d = {shift_q[WORD_BITS-2:0], sdi_sync};
          tmo_d   = '0;
          if (bit_cnt_q == LastBit) begin
            data_d    = {shift_q[WORD_BITS-2:0], sdi_sync};
            valid_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (tmo_q == TmoMax) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          tmo_d     = '0;
          ferr_d    = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Frame state, counters and registered outputs.
  always_ff @(posedge crystal_osc or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q == StShift);

endmodule

// File: tb/tb_adc_spi_rx.sv
// Directed bench for adc_spi_rx: reset, single/back-to-back frames, timeout,
// edge-at-expiry boundary and reset mid-frame.
`timescale 1ns / 1ps

module tb_adc_spi_rx;

  logic        crystal_osc = 1'b0;
  logic        rstn        = 1'b0;
  logic        sck         = 1'b0;
  logic        sdi         = 1'b0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        frame_error;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] words[$];
  int fe_cnt   = 0;
  int both_cnt = 0;
  int busy_bad = 0;

  adc_spi_rx #(
    .WORD_BITS      (16),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .crystal_osc   (crystal_osc),
    .rstn          (rstn),
    .adc_spi_clock (sck),
    .adc_spi_data  (sdi),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .frame_error   (frame_error),
    .busy          (busy)
  );

  // ~12.09 MHz
  always #41.35 crystal_osc = ~crystal_osc;

  // Record strobes on the falling edge, away from the active edge.
  always @(negedge crystal_osc) begin
    if (data_valid) words.push_back(data_out);
    if (frame_error) fe_cnt++;
    if (data_valid && frame_error) both_cnt++;
    if (data_valid && busy) busy_bad++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    words.delete();
    fe_cnt   = 0;
    both_cnt = 0;
    busy_bad = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge crystal_osc);
    #1;
  endtask

  // One SCK period with 375 ns phases, asynchronous to crystal_osc.
  task automatic bit_ns(input logic b);
    sdi = b;
    #375;
    sck = 1'b1;
    #375;
    sck = 1'b0;
  endtask

  // One SCK period with phases counted in crystal_osc cycles.
  task automatic bit_cyc(input logic b, input int lo, input int hi);
    sdi = b;
    tick(lo);
    sck = 1'b1;
    tick(hi);
    sck = 1'b0;
  endtask

  function automatic logic [15:0] word_at(input int idx);
    if (idx < words.size()) return words[idx];
    return 16'hxxxx;
  endfunction

  task automatic test_reset();
    clear_mon();
    rstn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sdi = 1'($urandom_range(0, 1));
      #375 sck = 1'b1;
      #375 sck = 1'b0;
    end
    tick(2);
    rstn = 1'b1;
    tick(5);
    checks++;
    if (data_out !== 16'h0000) begin
      errors++; $display("FAIL reset_data_out: got %h expected 0000", data_out);
    end
    checks++;
    if (data_valid !== 1'b0) begin
      errors++; $display("FAIL reset_data_valid: got %b expected 0", data_valid);
    end
    checks++;
    if (frame_error !== 1'b0) begin
      errors++; $display("FAIL reset_frame_error: got %b expected 0", frame_error);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (words.size() != 0 || fe_cnt != 0) begin
      errors++;
      $display("FAIL reset_strobes: got %0d valid %0d error expected 0 0", words.size(), fe_cnt);
    end
  endtask

  task automatic test_single();
    logic [15:0] w;
    w = 16'h96AA;
    clear_mon();
    for (int i = 15; i >= 0; i--) begin
      bit_ns(w[i]);
      if (i == 8) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL single_busy_mid: got %b expected 1", busy);
        end
      end
    end
    tick(10);
    checks++;
    if (words.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d expected 1", words.size());
    end
    checks++;
    if (word_at(0) !== 16'h96AA) begin
      errors++; $display("FAIL single_word: got %h expected 96aa", word_at(0));
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_after: got %b expected 0", busy);
    end
    tick(50);
    checks++;
    if (data_out !== 16'h96AA) begin
      errors++; $display("FAIL single_hold: got %h expected 96aa", data_out);
    end
    checks++;
    if (fe_cnt != 0) begin
      errors++; $display("FAIL single_no_error: got %0d expected 0", fe_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [15:0] b;
    a = 16'h5533;
    b = 16'h1655;
    clear_mon();
    for (int i = 15; i >= 0; i--) bit_ns(a[i]);
    for (int i = 15; i >= 0; i--) bit_ns(b[i]);
    tick(10);
    checks++;
    if (words.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d expected 2", words.size());
    end
    checks++;
    if (word_at(0) !== 16'h5533) begin
      errors++; $display("FAIL b2b_first: got %h expected 5533", word_at(0));
    end
    checks++;
    if (word_at(1) !== 16'h1655) begin
      errors++; $display("FAIL b2b_second: got %h expected 1655", word_at(1));
    end
    checks++;
    if (busy_bad != 0 || both_cnt != 0 || fe_cnt != 0) begin
      errors++;
      $display("FAIL b2b_flags: got busy_bad=%0d both=%0d err=%0d expected 0 0 0",
               busy_bad, both_cnt, fe_cnt);
    end
  endtask

  task automatic test_truncated();
    logic [15:0] w;
    logic [15:0] n;
    w = 16'h96AA;
    n = 16'h5533;
    clear_mon();
    for (int i = 15; i >= 1; i--) bit_cyc(w[i], 5, 5);
    // Last rise was 5 cycles ago; error is due 68 cycles after that rise.
    tick(55);
    checks++;
    if (busy !== 1'b1 || fe_cnt != 0) begin
      errors++;
      $display("FAIL trunc_early: got busy=%b err=%0d expected busy=1 err=0", busy, fe_cnt);
    end
    tick(45);
    checks++;
    if (fe_cnt != 1) begin
      errors++; $display("FAIL trunc_error_count: got %0d expected 1", fe_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL trunc_busy: got %b expected 0", busy);
    end
    checks++;
    if (data_out !== 16'h1655 || words.size() != 0) begin
      errors++;
      $display("FAIL trunc_data_kept: got %h (%0d strobes) expected 1655 (0 strobes)",
               data_out, words.size());
    end
    for (int i = 15; i >= 0; i--) bit_cyc(n[i], 5, 5);
    tick(10);
    checks++;
    if (words.size() != 1 || word_at(0) !== 16'h5533) begin
      errors++;
      $display("FAIL trunc_recover: got %h (%0d strobes) expected 5533 (1 strobe)",
               word_at(0), words.size());
    end
    checks++;
    if (fe_cnt != 1) begin
      errors++; $display("FAIL trunc_error_total: got %0d expected 1", fe_cnt);
    end
  endtask

  task automatic test_edge_at_expiry();
    logic [15:0] w;
    w = 16'h96AA;
    clear_mon();
    for (int i = 15; i >= 2; i--) bit_cyc(w[i], 5, 5);
    // 65-cycle rise spacing lands the detected edge on the saturated count.
    bit_cyc(w[1], 60, 5);
    bit_cyc(w[0], 5, 5);
    tick(10);
    checks++;
    if (fe_cnt != 0) begin
      errors++; $display("FAIL expiry_no_error: got %0d expected 0", fe_cnt);
    end
    checks++;
    if (words.size() != 1 || word_at(0) !== 16'h96AA) begin
      errors++;
      $display("FAIL expiry_word: got %h (%0d strobes) expected 96aa (1 strobe)",
               word_at(0), words.size());
    end
    checks++;
    if (data_out !== 16'h96AA) begin
      errors++; $display("FAIL expiry_data_out: got %h expected 96aa", data_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] p;
    logic [15:0] w;
    p = 16'hA5C3;
    w = 16'h1655;
    clear_mon();
    for (int i = 15; i >= 8; i--) bit_cyc(p[i], 5, 5);
    tick(2);
    rstn = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(3);
    checks++;
    if (busy !== 1'b0 || data_out !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_state: got busy=%b data=%h expected 0 0000", busy, data_out);
    end
    for (int i = 15; i >= 0; i--) bit_cyc(w[i], 5, 5);
    tick(100);
    checks++;
    if (words.size() != 1 || word_at(0) !== 16'h1655) begin
      errors++;
      $display("FAIL midreset_word: got %h (%0d strobes) expected 1655 (1 strobe)",
               word_at(0), words.size());
    end
    checks++;
    if (fe_cnt != 0) begin
      errors++; $display("FAIL midreset_no_error: got %0d expected 0", fe_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_truncated();
    test_edge_at_expiry();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
